// File: rtl/comm_calib_pkg.sv
// Shared definitions for the comm delay calibration controller.
//   state_t       : calibration FSM states
//   *_DEF         : default widths for the delay selects and error counter
//   popcount6     : number of set bits in a 6-bit symbol difference
package comm_calib_pkg;

  localparam int SEL_WIDTH_DEF = 4;
  localparam int ERR_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_NEXT,
    ST_FINAL,
    ST_DONE
  } state_t;

  function automatic logic [2:0] popcount6(input logic [5:0] x);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 6; i++) begin
      c = c + {2'b00, x[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/comm_err_accum.sv
// Saturating bit-error accumulator.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the sum (wins over en)
//   en       : add popcount(a ^ b) this cycle
//   a, b     : 6-bit symbols to compare
//   sum      : registered error total, sticks at all-ones instead of wrapping
module comm_err_accum
  import comm_calib_pkg::*;
#(
  parameter int ERR_WIDTH = ERR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [5:0]           a,
  input  logic [5:0]           b,
  output logic [ERR_WIDTH-1:0] sum
);

  localparam int WIDE_W = ERR_WIDTH + 1;

  logic [ERR_WIDTH-1:0] sum_q, sum_d;
  logic [WIDE_W-1:0]    wide;

  // One extra bit catches the carry so the total can clamp at all-ones.
  always_comb begin
    wide  = {1'b0, sum_q} + WIDE_W'(popcount6(a ^ b));
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = wide[ERR_WIDTH] ? '1 : wide[ERR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/comm_delay_calib.sv
// Calibration controller for the comm loopback path. Sweeps every
// (sample delay, valid delay) pair, counts bit errors between raw_send_d and
// raw_recv at each pair, and programs the pair with the fewest errors.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   start, abort                 : begin a sweep / return to IDLE (abort wins)
//   manual_en, manual_sample,
//   manual_valid                 : manual delay override while not sweeping
//   raw_send_d, raw_recv,
//   valid_raw_recv               : aligned tx symbol, rx symbol, word strobe
//   ad1_delay, ad2_delay,
//   ad_valid_delay               : delay selects to the comm block
//   flush                        : 1-cycle pulse whenever the setting changes
//   busy, done, locked, best_err : sweep status and committed result
module comm_delay_calib
  import comm_calib_pkg::*;
#(
  parameter int SEL_WIDTH = SEL_WIDTH_DEF,
  parameter int SAMPLES   = 256,
  parameter int SETTLE    = 64,
  parameter int TIMEOUT   = 4096,
  parameter int ERR_WIDTH = ERR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 manual_en,
  input  logic [SEL_WIDTH-1:0] manual_sample,
  input  logic [SEL_WIDTH-1:0] manual_valid,
  input  logic [5:0]           raw_send_d,
  input  logic [5:0]           raw_recv,
  input  logic                 valid_raw_recv,
  output logic [SEL_WIDTH-1:0] ad1_delay,
  output logic [SEL_WIDTH-1:0] ad2_delay,
  output logic [SEL_WIDTH-1:0] ad_valid_delay,
  output logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic [ERR_WIDTH-1:0] best_err
);

  localparam int CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] s_q, s_d, v_q, v_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic [SEL_WIDTH-1:0] cand_s_q, cand_s_d, cand_v_q, cand_v_d;
  logic [ERR_WIDTH-1:0] cand_err_q, cand_err_d;
  logic [SEL_WIDTH-1:0] best_s_q, best_s_d, best_v_q, best_v_d;
  logic [ERR_WIDTH-1:0] best_err_q, best_err_d;
  logic                 locked_q, locked_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 flush_q, flush_d;

  logic                 acc_clear, acc_en;
  logic [ERR_WIDTH-1:0] acc_sum;
  logic [ERR_WIDTH-1:0] meas_err;
  logic                 sweeping;

  comm_err_accum #(
    .ERR_WIDTH(ERR_WIDTH)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear),
    .en    (acc_en),
    .a     (raw_send_d),
    .b     (raw_recv),
    .sum   (acc_sum)
  );

  // Next-state logic for the sweep FSM, counters, candidate and committed best.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    v_d        = v_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    cand_s_d   = cand_s_q;
    cand_v_d   = cand_v_q;
    cand_err_d = cand_err_q;
    best_s_d   = best_s_q;
    best_v_d   = best_v_q;
    best_err_d = best_err_q;
    locked_d   = locked_q;
    done_d     = done_q;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    sweeping   = state_q inside {ST_APPLY, ST_SETTLE, ST_MEASURE, ST_EVAL, ST_NEXT};
    // A timed-out point is scored as worst possible so it can never win.
    meas_err   = tmo_flag_q ? '1 : acc_sum;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (start) begin
          state_d    = ST_APPLY;
          s_d        = '0;
          v_d        = '0;
          cand_s_d   = '0;
          cand_v_d   = '0;
          cand_err_d = '1;
          done_d     = 1'b0;
        end
      end
      ST_APPLY: begin
        state_d    = ST_SETTLE;
        cnt_d      = '0;
        tmo_flag_d = 1'b0;
        acc_clear  = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        // A final word arriving on the last timeout cycle still counts as complete.
        acc_en = valid_raw_recv;
        tmo_d  = tmo_q + TMO_W'(1);
        if (valid_raw_recv) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (valid_raw_recv && (cnt_q == CNT_W'(SAMPLES - 1))) begin
          state_d = ST_EVAL;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d    = ST_EVAL;
          tmo_flag_d = 1'b1;
        end
      end
      ST_EVAL: begin
        // Strict less-than: on a tie the earlier point in sweep order is kept.
        if (meas_err < cand_err_q) begin
          cand_s_d   = s_q;
          cand_v_d   = v_q;
          cand_err_d = meas_err;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (v_q == '1) begin
          v_d = '0;
          if (s_q == '1) begin
            state_d    = ST_FINAL;
            best_s_d   = cand_s_q;
            best_v_d   = cand_v_q;
            best_err_d = cand_err_q;
            locked_d   = (cand_err_q == '0);
          end else begin
            s_d     = s_q + SEL_WIDTH'(1);
            state_d = ST_APPLY;
          end
        end else begin
          v_d     = v_q + SEL_WIDTH'(1);
          state_d = ST_APPLY;
        end
      end
      ST_FINAL: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort mid-sweep discards everything, including a commit that was about to happen.
    if (abort && sweeping) begin
      state_d    = ST_IDLE;
      best_s_d   = best_s_q;
      best_v_d   = best_v_q;
      best_err_d = best_err_q;
      locked_d   = locked_q;
      done_d     = 1'b0;
    end

    busy_d  = state_d inside {ST_APPLY, ST_SETTLE, ST_MEASURE, ST_EVAL, ST_NEXT};
    flush_d = (state_d == ST_APPLY) || (state_d == ST_FINAL) || (abort && sweeping);
  end

  // All controller state, registered on one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      v_q        <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
      cand_s_q   <= '0;
      cand_v_q   <= '0;
      cand_err_q <= '1;
      best_s_q   <= '0;
      best_v_q   <= '0;
      best_err_q <= '1;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      v_q        <= v_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
      cand_s_q   <= cand_s_d;
      cand_v_q   <= cand_v_d;
      cand_err_q <= cand_err_d;
      best_s_q   <= best_s_d;
      best_v_q   <= best_v_d;
      best_err_q <= best_err_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flush_q    <= flush_d;
    end
  end

  // Sweep point wins while busy; otherwise manual override or committed best.
  always_comb begin
    if (busy_q) begin
      ad1_delay      = s_q;
      ad_valid_delay = v_q;
    end else if (manual_en) begin
      ad1_delay      = manual_sample;
      ad_valid_delay = manual_valid;
    end else begin
      ad1_delay      = best_s_q;
      ad_valid_delay = best_v_q;
    end
  end

  assign ad2_delay = ad1_delay;
  assign flush     = flush_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign locked    = locked_q;
  assign best_err  = best_err_q;

endmodule

// File: tb/tb_comm_delay_calib.sv
// Self-checking bench for comm_delay_calib, built with reduced sweep sizes.
// A loopback emulator produces per-point error patterns from a table; the
// expected winner of each sweep is computed from that table and queued, and
// a monitor checks it when done rises, along with sweep order and flush count.
module tb_comm_delay_calib;

  localparam int SW      = 3;
  localparam int SAMPLES = 12;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 40;
  localparam int EW      = 6;
  localparam int NV      = 1 << SW;
  localparam int NPTS    = NV * NV;
  localparam int MAXE    = (1 << EW) - 1;
  localparam int LIMIT   = 6000;

  typedef struct {
    int d1;
    int dv;
    int err;
    int lk;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          manual_en;
  logic [SW-1:0] manual_sample;
  logic [SW-1:0] manual_valid;
  logic [5:0]    raw_send_d;
  logic [5:0]    raw_recv;
  logic          valid_raw_recv;
  logic [SW-1:0] ad1_delay;
  logic [SW-1:0] ad2_delay;
  logic [SW-1:0] ad_valid_delay;
  logic          flush;
  logic          busy;
  logic          done;
  logic          locked;
  logic [EW-1:0] best_err;

  int   n_compared;
  int   n_mismatched;
  exp_t sb_q[$];
  int   err_tab[NPTS];
  bit   nov_tab[NPTS];
  int   m_s, m_v, m_err, m_lk;

  comm_delay_calib #(
    .SEL_WIDTH (SW),
    .SAMPLES   (SAMPLES),
    .SETTLE    (SETTLE),
    .TIMEOUT   (TIMEOUT),
    .ERR_WIDTH (EW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .manual_en      (manual_en),
    .manual_sample  (manual_sample),
    .manual_valid   (manual_valid),
    .raw_send_d     (raw_send_d),
    .raw_recv       (raw_recv),
    .valid_raw_recv (valid_raw_recv),
    .ad1_delay      (ad1_delay),
    .ad2_delay      (ad2_delay),
    .ad_valid_delay (ad_valid_delay),
    .flush          (flush),
    .busy           (busy),
    .done           (done),
    .locked         (locked),
    .best_err       (best_err)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one-cycle start/abort pulses just after a rising edge.
  task automatic applyStimulus(input bit do_start, input bit do_abort);
    @(posedge clk);
    #1;
    start = do_start;
    abort = do_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic logic [5:0] errMask(input int e);
    logic [5:0] m;
    int         n;
    int         b;
    m = 6'd0;
    n = 0;
    while (n < e) begin
      b = $urandom_range(5);
      if (!m[b]) begin
        m[b] = 1'b1;
        n++;
      end
    end
    return m;
  endfunction

  // Fills the per-point loopback behaviour: errors per word and whether valid stalls.
  task automatic setScenario(input int kind);
    int sp;
    sp = $urandom_range(NPTS - 1);
    for (int i = 0; i < NPTS; i++) begin
      nov_tab[i] = 1'b0;
      case (kind)
        0: err_tab[i] = (i == sp) ? 0 : 1;
        1: err_tab[i] = 3;
        2: begin
          if (i / NV == 2) begin
            err_tab[i] = 0;
            nov_tab[i] = 1'b1;
          end else begin
            err_tab[i] = $urandom_range(6, 1);
          end
        end
        default: err_tab[i] = $urandom_range(6);
      endcase
    end
  endtask

  // Winner is the first point in sweep order with the strictly smallest score.
  task automatic modelBest(output int bs, output int bv, output int be);
    int tot;
    bs = 0;
    bv = 0;
    be = MAXE;
    for (int i = 0; i < NPTS; i++) begin
      if (nov_tab[i]) begin
        tot = MAXE;
      end else begin
        tot = SAMPLES * err_tab[i];
        if (tot > MAXE) tot = MAXE;
      end
      if (tot < be) begin
        be = tot;
        bs = i / NV;
        bv = i % NV;
      end
    end
  endtask

  task automatic runSweep(input int kind, input bit stray_start);
    exp_t e;
    int   cyc;
    setScenario(kind);
    modelBest(m_s, m_v, m_err);
    m_lk  = (m_err == 0) ? 1 : 0;
    e.d1  = manual_en ? int'(manual_sample) : m_s;
    e.dv  = manual_en ? int'(manual_valid) : m_v;
    e.err = m_err;
    e.lk  = m_lk;
    sb_q.push_back(e);
    applyStimulus(1'b1, 1'b0);
    if (stray_start) begin
      repeat (200) @(posedge clk);
      applyStimulus(1'b1, 1'b0);
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("sweep_completes", (cyc < LIMIT) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
  endtask

  // Loopback emulator: behaviour depends on the delay setting the DUT drives.
  initial begin
    int         idx;
    logic [5:0] snd;
    valid_raw_recv = 1'b0;
    raw_send_d     = 6'd0;
    raw_recv       = 6'd0;
    forever begin
      @(posedge clk);
      #1;
      idx            = int'(ad1_delay) * NV + int'(ad_valid_delay);
      valid_raw_recv = nov_tab[idx] ? 1'b0 : ($urandom_range(3) != 0);
      snd            = 6'($urandom);
      raw_send_d     = snd;
      raw_recv       = snd ^ errMask(err_tab[idx]);
    end
  end

  // Monitor: sweep order on each busy flush, scoreboard pop on each done rise.
  initial begin
    bit   prev_busy;
    bit   prev_done;
    int   flush_cnt;
    int   exp_idx;
    exp_t e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    flush_cnt = 0;
    exp_idx   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          flush_cnt = 0;
          exp_idx   = 0;
        end
        if (flush) begin
          flush_cnt++;
          if (busy) begin
            checkOutput("sweep_order_s", ad1_delay, exp_idx / NV);
            checkOutput("sweep_order_ad2", ad2_delay, exp_idx / NV);
            checkOutput("sweep_order_v", ad_valid_delay, exp_idx % NV);
            exp_idx++;
          end
        end
        if (done && !prev_done) begin
          checkOutput("done_expected", (sb_q.size() > 0) ? 1 : 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("result_ad1", ad1_delay, e.d1);
            checkOutput("result_ad2", ad2_delay, e.d1);
            checkOutput("result_valid_delay", ad_valid_delay, e.dv);
            checkOutput("result_best_err", best_err, e.err);
            checkOutput("result_locked", locked, e.lk);
            checkOutput("result_busy", busy, 0);
            checkOutput("flush_pulses", flush_cnt, NPTS + 1);
          end
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  task automatic abortAtPoint(input int pt);
    int cyc;
    bit found;
    applyStimulus(1'b1, 1'b0);
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (flush && busy && (int'(ad1_delay) * NV + int'(ad_valid_delay) == pt)) found = 1'b1;
    end
    checkOutput("abort_point_reached", found, 1);
    repeat (SETTLE + 3) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_flush", flush, 1);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ad1", ad1_delay, m_s);
    checkOutput("abort_valid_delay", ad_valid_delay, m_v);
    checkOutput("abort_best_err", best_err, m_err);
    @(negedge clk);
    checkOutput("abort_flush_single", flush, 0);
  endtask

  // Overall time bound so the run can never hang.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    rst           = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    manual_en     = 1'b0;
    manual_sample = '0;
    manual_valid  = '0;
    m_s           = 0;
    m_v           = 0;
    m_err         = MAXE;
    m_lk          = 0;
    for (int i = 0; i < NPTS; i++) begin
      err_tab[i] = 0;
      nov_tab[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset_ad1", ad1_delay, 0);
    checkOutput("reset_ad2", ad2_delay, 0);
    checkOutput("reset_valid_delay", ad_valid_delay, 0);
    checkOutput("reset_best_err", best_err, MAXE);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_flush", flush, 0);

    $display("[TB] start with abort in the same cycle");
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_flush", flush, 0);

    $display("[TB] abort mid-measure after reset");
    setScenario(3);
    abortAtPoint(10);

    $display("[TB] single clean point");
    runSweep(0, 1'b0);

    $display("[TB] uniform errors, stray start mid-sweep");
    runSweep(1, 1'b1);

    $display("[TB] stalled valid at s=2");
    runSweep(2, 1'b0);
    checkOutput("timeout_point_not_chosen", (ad1_delay == 2) ? 1 : 0, 0);

    $display("[TB] abort after a committed sweep");
    setScenario(3);
    abortAtPoint(21);

    $display("[TB] manual override");
    manual_en     = 1'b1;
    manual_sample = 3'd3;
    manual_valid  = 3'd7;
    @(negedge clk);
    checkOutput("manual_ad1", ad1_delay, 3);
    checkOutput("manual_ad2", ad2_delay, 3);
    checkOutput("manual_valid_delay", ad_valid_delay, 7);
    runSweep(3, 1'b0);
    manual_en = 1'b0;
    @(negedge clk);
    checkOutput("post_manual_ad1", ad1_delay, m_s);
    checkOutput("post_manual_valid_delay", ad_valid_delay, m_v);

    $display("[TB] random sweep restarted from done");
    runSweep(3, 1'b0);

    $display("[TB] reset mid-sweep");
    setScenario(3);
    applyStimulus(1'b1, 1'b0);
    repeat (300) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_ad1", ad1_delay, 0);
    checkOutput("midreset_valid_delay", ad_valid_delay, 0);
    checkOutput("midreset_best_err", best_err, MAXE);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_locked", locked, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_s   = 0;
    m_v   = 0;
    m_err = MAXE;
    m_lk  = 0;
    repeat (2) @(negedge clk);

    $display("[TB] random sweep after reset");
    runSweep(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
